cipher_tx_uart: RTL and testbench

CIPHER_TX_UART -- requirements
Module: cipher_tx_uart

---
 rtl/cipher_tx_uart.sv | 176 +++++++++++++++++
 tb/tb_cipher_tx_uart.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/cipher_tx_uart.sv
// Purpose: 8-entry byte FIFO fed by PicoBlaze port writes, drained by an 8N1 UART transmitter.
// Latency: push into an empty idle FIFO -> tx falls (start bit) 1 clk later; frame = 10 (11) bit times.
// Backpressure: none upstream; a push into a full FIFO without a same-edge pop is dropped and sets sticky overflow.
// Optional: define CIPHER_TX_PARITY_EN to insert an even-parity bit between data bit 7 and stop.
module cipher_tx_uart #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter logic [7:0]  DATA_ADDR    = 8'h04,
  parameter logic [7:0]  STATUS_ADDR  = 8'h05
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] port_id,
  input  logic [7:0] out_port,
  input  logic       write_strobe,
  output logic       tx,
  output logic [7:0] status
);

`ifdef CIPHER_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  localparam logic [15:0] BIT_LAST = 16'(CLKS_PER_BIT - 1);

  // FIFO storage and bookkeeping
  logic [7:0] fifo_mem [8];
  logic [2:0] wr_ptr;
  logic [2:0] rd_ptr;
  logic [3:0] count;
  logic       full;
  logic       empty;
  logic       overflow;

  // Transmitter state
  state_t      state, state_d;
  logic [15:0] bit_cnt, bit_cnt_d;
  logic [2:0]  bit_idx, bit_idx_d;
  logic [2:0]  idx_nxt;
  logic        tx_d;
  logic [7:0]  shift_reg;
  logic        pop;

  logic push_req;
  logic clr_req;
  logic push_ok;
  logic busy;

  assign full     = (count == 4'd8);
  assign empty    = (count == 4'd0);
  assign push_req = write_strobe && (port_id == DATA_ADDR);
  assign clr_req  = write_strobe && (port_id == STATUS_ADDR);
  // A pop on the same edge frees a slot, so a push into a full FIFO still lands.
  assign push_ok  = push_req && (!full || pop);
  assign busy     = (state != IDLE);
  assign status   = {5'b0, overflow, full, busy};
  assign idx_nxt  = bit_idx + 3'd1;

  // FIFO data array; contents are don't-care until written, so no reset
  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr] <= out_port;
  end

  // FIFO pointers, occupancy and sticky overflow (set wins over clear)
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 3'd1;
      if (pop)     rd_ptr <= rd_ptr + 3'd1;
      case ({push_ok, pop})
        2'b10:   count <= count + 4'd1;
        2'b01:   count <= count - 4'd1;
        default: count <= count;
      endcase
      if (push_req && full && !pop) overflow <= 1'b1;
      else if (clr_req)             overflow <= 1'b0;
    end
  end

  // Transmitter state register; tx is a flop so the line never glitches
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      bit_idx   <= '0;
      tx        <= 1'b1;
      shift_reg <= '0;
    end else begin
      state   <= state_d;
      bit_cnt <= bit_cnt_d;
      bit_idx <= bit_idx_d;
      tx      <= tx_d;
      if (pop) shift_reg <= fifo_mem[rd_ptr];
    end
  end

  // Next-state and next-tx: each state holds for CLKS_PER_BIT cycles, counter reloads on change
  always_comb begin
    state_d   = state;
    bit_cnt_d = bit_cnt;
    bit_idx_d = bit_idx;
    tx_d      = tx;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        tx_d = 1'b1;
        if (!empty) begin
          pop       = 1'b1;
          state_d   = START;
          bit_cnt_d = '0;
          tx_d      = 1'b0;
        end
      end
      START: begin
        if (bit_cnt == BIT_LAST) begin
          state_d   = DATA;
          bit_cnt_d = '0;
          bit_idx_d = '0;
          tx_d      = shift_reg[0];
        end else begin
          bit_cnt_d = bit_cnt + 16'd1;
        end
      end
      DATA: begin
        if (bit_cnt == BIT_LAST) begin
          bit_cnt_d = '0;
          if (bit_idx == 3'd7) begin
`ifdef CIPHER_TX_PARITY_EN
            state_d = PARITY;
            tx_d    = ^shift_reg;
`else
            state_d = STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            bit_idx_d = idx_nxt;
            tx_d      = shift_reg[idx_nxt];
          end
        end else begin
          bit_cnt_d = bit_cnt + 16'd1;
        end
      end
`ifdef CIPHER_TX_PARITY_EN
      PARITY: begin
        if (bit_cnt == BIT_LAST) begin
          state_d   = STOP;
          bit_cnt_d = '0;
          tx_d      = 1'b1;
        end else begin
          bit_cnt_d = bit_cnt + 16'd1;
        end
      end
`endif
      STOP: begin
        if (bit_cnt == BIT_LAST) begin
          state_d   = IDLE;
          bit_cnt_d = '0;
          tx_d      = 1'b1;
        end else begin
          bit_cnt_d = bit_cnt + 16'd1;
        end
      end
      default: begin
        state_d   = IDLE;
        bit_cnt_d = '0;
        tx_d      = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_cipher_tx_uart.sv
// Bench for cipher_tx_uart with CLKS_PER_BIT=4: a scoreboard queue of expected bytes
// is filled as pushes are driven and consumed by a tx line monitor that decodes each frame.
module tb_cipher_tx_uart;

  localparam int CPB = 4;
`ifdef CIPHER_TX_PARITY_EN
  localparam int NSLOT = 11;
`else
  localparam int NSLOT = 10;
`endif
  localparam int FRAME_CYC = NSLOT * CPB;
  localparam logic [7:0] DATA_ADDR   = 8'h04;
  localparam logic [7:0] STATUS_ADDR = 8'h05;

  logic       clk;
  logic       reset_n;
  logic [7:0] port_id;
  logic [7:0] out_port;
  logic       write_strobe;
  logic       tx;
  logic [7:0] status;

  int n_checks;
  int n_pass;
  int cyc;
  int frames_done;
  int prev_start;
  int last_start;
  bit in_frame;
  logic [7:0] exp_q [$];

  cipher_tx_uart #(
    .CLKS_PER_BIT(CPB),
    .DATA_ADDR(DATA_ADDR),
    .STATUS_ADDR(STATUS_ADDR)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .port_id(port_id),
    .out_port(out_port),
    .write_strobe(write_strobe),
    .tx(tx),
    .status(status)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Expected tx samples for one frame, one bit per clock, bit 0 = first start-bit cycle
  function automatic logic [63:0] exp_frame(input logic [7:0] b);
    logic [63:0] v;
    logic        bv;
    v = '0;
    for (int s = 0; s < NSLOT; s++) begin
      if (s == 0)              bv = 1'b0;
      else if (s <= 8)         bv = b[s-1];
      else if (s == NSLOT - 1) bv = 1'b1;
      else                     bv = ^b;
      for (int k = 0; k < CPB; k++) v[s*CPB + k] = bv;
    end
    return v;
  endfunction

  // Single write cycle: inputs change at a negedge, one rising edge sees the strobe
  task automatic port_write(input logic [7:0] addr, input logic [7:0] data);
    port_id      = addr;
    out_port     = data;
    write_strobe = 1'b1;
    @(negedge clk);
    write_strobe = 1'b0;
  endtask

  task automatic push_byte(input logic [7:0] data, input bit accept);
    if (accept) exp_q.push_back(data);
    port_write(DATA_ADDR, data);
  endtask

  task automatic wait_drain(input int budget, input string tag);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !in_frame && status[0] == 1'b0) done = 1'b1;
    end
    check_eq(tag, 64'(done), 64'd1);
  endtask

  // tx monitor: decodes frames at negedges and compares against the scoreboard
  logic [63:0] obs_bits;
  logic [63:0] obs_busy;
  logic [7:0]  mon_byte;
  bit          aborted;
  initial begin : monitor
    in_frame = 1'b0;
    forever begin
      @(negedge clk);
      if (reset_n === 1'b1 && tx === 1'b0) begin
        in_frame   = 1'b1;
        prev_start = last_start;
        last_start = cyc;
        check_eq("frame_expected", 64'(exp_q.size() != 0), 64'd1);
        mon_byte = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
        obs_bits = '0;
        obs_busy = '0;
        aborted  = 1'b0;
        for (int i = 0; i < FRAME_CYC; i++) begin
          if (i > 0) @(negedge clk);
          if (reset_n !== 1'b1) begin
            aborted = 1'b1;
            break;
          end
          obs_bits[i] = tx;
          obs_busy[i] = status[0];
        end
        if (!aborted) begin
          @(negedge clk);
          if (reset_n === 1'b1) begin
            check_eq("frame_bits", obs_bits, exp_frame(mon_byte));
            check_eq("frame_busy", obs_busy, (64'd1 << FRAME_CYC) - 64'd1);
            check_eq("idle_gap_tx", 64'(tx), 64'd1);
            check_eq("idle_gap_busy", 64'(status[0]), 64'd0);
            frames_done++;
          end
        end
        in_frame = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: time limit reached, got %0d checks expected completion", n_checks);
    $fatal(1, "watchdog");
  end

  int frames_before;
  bit saw_start;
  initial begin : stim
    n_checks     = 0;
    n_pass       = 0;
    cyc          = 0;
    frames_done  = 0;
    prev_start   = 0;
    last_start   = 0;
    reset_n      = 1'b0;
    port_id      = 8'h00;
    out_port     = 8'h00;
    write_strobe = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check_eq("reset_tx", 64'(tx), 64'd1);
    check_eq("reset_status", 64'(status), 64'h00);

    // First push honoured on the first edge after release; start bit one cycle later
    reset_n = 1'b1;
    push_byte(8'hA5, 1'b1);
    check_eq("lat_before_start", 64'(tx), 64'd1);
    @(negedge clk);
    check_eq("lat_start_bit", 64'(tx), 64'd0);
    wait_drain(200, "a5_drain");
    check_eq("a5_status_idle", 64'(status), 64'h00);
    check_eq("a5_frames", 64'(frames_done), 64'd1);

    // Back-to-back frames: exactly one idle cycle between stop end and next start
    push_byte(8'h3C, 1'b1);
    push_byte(8'hC3, 1'b1);
    wait_drain(300, "b2b_drain");
    check_eq("b2b_start_spacing", 64'(last_start - prev_start), 64'(FRAME_CYC + 1));

    // Ten consecutive pushes: nine accepted, tenth dropped with overflow
    for (int i = 0; i < 10; i++) begin
      port_id      = DATA_ADDR;
      out_port     = 8'h10 + 8'(i);
      write_strobe = 1'b1;
      if (i < 9) exp_q.push_back(8'h10 + 8'(i));
      @(negedge clk);
    end
    write_strobe = 1'b0;
    check_eq("burst_status", 64'(status), 64'h07);
    port_write(8'h06, 8'hEE);
    check_eq("port6_keeps_overflow", 64'(status[2]), 64'd1);
    port_write(STATUS_ADDR, 8'h00);
    check_eq("status_clears_overflow", 64'(status[2]), 64'd0);
    wait_drain(1000, "burst_drain");
    check_eq("burst_frames", 64'(frames_done), 64'd12);
    check_eq("burst_status_idle", 64'(status), 64'h00);

    // Frame whose parity bit is 1 when parity is enabled
    push_byte(8'h07, 1'b1);
    wait_drain(200, "p07_drain");

    // Reset mid-frame aborts and nothing resumes afterwards
    push_byte(8'h5A, 1'b1);
    saw_start = 1'b0;
    for (int i = 0; i < 20 && !saw_start; i++) begin
      @(negedge clk);
      if (in_frame) saw_start = 1'b1;
    end
    check_eq("abort_frame_started", 64'(saw_start), 64'd1);
    frames_before = frames_done;
    repeat (12) @(negedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check_eq("abort_tx_high", 64'(tx), 64'd1);
    check_eq("abort_status", 64'(status), 64'h00);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (100) @(negedge clk);
    check_eq("abort_no_resume_tx", 64'(tx), 64'd1);
    check_eq("abort_no_frames", 64'(frames_done), 64'(frames_before));
    check_eq("abort_status_idle", 64'(status), 64'h00);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
